// File: rtl/text_console_pkg.sv
// text_console_pkg: shared states, cursor operations, control codes and the ASCII-to-glyph decode.
package text_console_pkg;
   typedef enum logic {IDLE, CLEAR} state_e;
   typedef enum logic [2:0] {CUR_NONE, CUR_ADV, CUR_LF, CUR_CR, CUR_BS, CUR_HOME} cur_op_e;
   localparam logic [7:0] LF = 8'h0A;
   localparam logic [7:0] CR = 8'h0D;
   localparam logic [7:0] BS = 8'h08;
   localparam logic [7:0] FF = 8'h0C;
   // Returns {hit, glyph}; only hex digits have a glyph.
   function automatic logic [4:0] ascii_to_glyph(input logic [7:0] c);
      if (c >= 8'h30 && c <= 8'h39) return {1'b1, c[3:0]};
      if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) return {1'b1, c[3:0] + 4'd9};
      return 5'd0;
   endfunction
endpackage

// File: rtl/text_console_if.sv
// text_console_if: CPU byte handshake, text-buffer write port and cursor position.
interface text_console_if;
   logic [7:0]  char_in;
   logic        char_valid;
   logic        char_ready;
   logic [3:0]  new_char;
   logic [11:0] waddr;
   logic        text_en;
   logic [4:0]  cursor_row;
   logic [6:0]  cursor_col;
   modport master (output char_in, char_valid, input char_ready, new_char, waddr, text_en, cursor_row, cursor_col);
   modport slave (input char_in, char_valid, output char_ready, new_char, waddr, text_en, cursor_row, cursor_col);
endinterface

// File: rtl/text_cursor.sv
// text_cursor: row/column plus incrementally maintained linear address row*COLS+col.
module text_cursor
   import text_console_pkg::*;
#(
   parameter int COLS = 80,
   parameter int ROWS = 30
) (
   input  logic        clk,
   input  logic        rst_n,
   input  cur_op_e     op_i,
   output logic [4:0]  row_o,
   output logic [6:0]  col_o,
   output logic [11:0] addr_o
);
   logic [4:0]  row_q, row_d;
   logic [6:0]  col_q, col_d;
   logic [11:0] addr_q, addr_d;
   logic        last_col, last_row;
   assign last_col = col_q == 7'(COLS - 1);
   assign last_row = row_q == 5'(ROWS - 1);
   always_comb begin
      row_d = row_q;
      col_d = col_q;
      addr_d = addr_q;
      case (op_i)
         CUR_ADV: begin
            col_d = last_col ? 7'd0 : col_q + 7'd1;
            row_d = !last_col ? row_q : last_row ? 5'd0 : row_q + 5'd1;
            addr_d = (last_col && last_row) ? 12'd0 : addr_q + 12'd1;
         end
         CUR_LF: begin
            col_d = 7'd0;
            row_d = last_row ? 5'd0 : row_q + 5'd1;
            addr_d = last_row ? 12'd0 : addr_q - 12'(col_q) + 12'(COLS);
         end
         CUR_CR: begin
            col_d = 7'd0;
            addr_d = addr_q - 12'(col_q);
         end
         CUR_BS: begin
            col_d = (col_q != 7'd0) ? col_q - 7'd1 : col_q;
            addr_d = (col_q != 7'd0) ? addr_q - 12'd1 : addr_q;
         end
         CUR_HOME: begin
            row_d = 5'd0;
            col_d = 7'd0;
            addr_d = 12'd0;
         end
         default: ;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         row_q <= 5'd0;
         col_q <= 7'd0;
         addr_q <= 12'd0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
         addr_q <= addr_d;
      end
   end
   assign row_o = row_q;
   assign col_o = col_q;
   assign addr_o = addr_q;
endmodule

// File: rtl/text_console.sv
// text_console: turns CPU console bytes into text-buffer cell writes, with cursor control
// and a back-pressured clear-screen sequence.
module text_console
   import text_console_pkg::*;
#(
   parameter int          COLS        = 80,
   parameter int          ROWS        = 30,
   parameter logic [3:0]  CLEAR_GLYPH = 4'h0
) (
   input logic         clk,
   input logic         rst_n,
   text_console_if.slave bus
);
   localparam int CELLS = ROWS * COLS;
   state_e      state_q, state_d;
   logic [12:0] cnt_q, cnt_d;
   logic        ready_q, ready_d, en_q, en_d, acc, printable;
   logic [11:0] waddr_q, waddr_d, addr;
   logic [3:0]  glyph_q, glyph_d;
   logic [4:0]  g;
   cur_op_e     op;
   assign acc = bus.char_valid & ready_q;
   assign g = ascii_to_glyph(bus.char_in);
   assign printable = bus.char_in >= 8'h20 && bus.char_in <= 8'h7E;
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      en_d = 1'b0;
      waddr_d = waddr_q;
      glyph_d = glyph_q;
      op = CUR_NONE;
      if (state_q == IDLE) begin
         op = !acc ? CUR_NONE : printable ? CUR_ADV : bus.char_in == LF ? CUR_LF :
              bus.char_in == CR ? CUR_CR : bus.char_in == BS ? CUR_BS : CUR_NONE;
         if (acc && g[4]) begin
            en_d = 1'b1;
            waddr_d = addr;
            glyph_d = g[3:0];
         end else if (acc && bus.char_in == FF) begin
            // Cell 0 is written on the accept edge, so the counter resumes at 1.
            state_d = CLEAR;
            en_d = 1'b1;
            waddr_d = 12'd0;
            glyph_d = CLEAR_GLYPH;
            cnt_d = 13'd1;
         end
      end else if (cnt_q == 13'(CELLS)) begin
         state_d = IDLE;
         cnt_d = 13'd0;
         op = CUR_HOME;
      end else begin
         en_d = 1'b1;
         waddr_d = cnt_q[11:0];
         glyph_d = CLEAR_GLYPH;
         cnt_d = cnt_q + 13'd1;
      end
   end
   assign ready_d = state_d == IDLE;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q <= 13'd0;
         ready_q <= 1'b0;
         en_q <= 1'b0;
         waddr_q <= 12'd0;
         glyph_q <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         ready_q <= ready_d;
         en_q <= en_d;
         waddr_q <= waddr_d;
         glyph_q <= glyph_d;
      end
   end
   text_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
      .clk    (clk),
      .rst_n  (rst_n),
      .op_i   (op),
      .row_o  (bus.cursor_row),
      .col_o  (bus.cursor_col),
      .addr_o (addr)
   );
   assign bus.char_ready = ready_q;
   assign bus.text_en = en_q;
   assign bus.waddr = waddr_q;
   assign bus.new_char = glyph_q;
endmodule

// File: doc/text_console.md
Name: text_console

Overview:
- Upstream neighbour of the character display pipeline: turns the CPU's byte-wide console output (display-data-register writes) into text-buffer cell writes (new_char, waddr, text_en).
- Converts ASCII to the 4-bit glyph code, keeps the cursor row/column, and handles control characters.
- Runs a multi-cycle clear-screen sequence, back-pressuring the CPU through char_ready (maps to the display-status ready bit).

Parameters:
- COLS, 80, text columns (640 px / 8 px glyph width).
- ROWS, 30, text rows (480 px / 16 px glyph height). ROWS*COLS must be <= 4096.
- CLEAR_GLYPH, 4'h0, glyph code written to every cell during clear. Integration sets it to the blank glyph.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- char_in  input  8  ASCII byte from CPU
- char_valid  input  1  char_in valid; held until accepted
- char_ready  output  1  block can accept a byte this cycle
- new_char  output  4  glyph code to text buffer
- waddr  output  12  linear cell address (row*COLS + col) to text buffer
- text_en  output  1  one-cycle write strobe to text buffer
- cursor_row  output  5  current cursor row, 0..ROWS-1
- cursor_col  output  7  current cursor column, 0..COLS-1

Behaviour:
- Reset values: char_ready=0 during reset, 1 the first cycle after. new_char=0, waddr=0, text_en=0, cursor_row=0, cursor_col=0, state=IDLE, linear address register=0.
- Accept condition: char_valid && char_ready. char_ready=1 only in IDLE.
- All outputs are registered. A write caused by an accepted byte appears on text_en/waddr/new_char exactly 1 cycle after accept. text_en is high for exactly 1 cycle per write.
- Linear address register holds row*COLS+col incrementally; no multiplier is allowed.
- Glyph map (printable characters):
  - '0'-'9' map to 0-9.
  - 'A'-'F' and 'a'-'f' map to 10-15.
  - Action: write the glyph at the cursor, then advance the cursor.
- Space and any other printable byte (0x20-0x7E) without a glyph: advance the cursor, no write.
- Advance rule:
  - col+1.
  - If col==COLS-1: col=0, row+1.
  - If row was ROWS-1 as well: wrap to (0,0) and address 0. No scrolling.
- 0x0A LF: col=0, row+1 (wraps ROWS-1 to 0). address = address - col + COLS, wrapping modulo ROWS*COLS. No write.
- 0x0D CR: col=0, address -= col. No write.
- 0x08 BS: if col>0 then col-1 and address-1. At col 0, no change (never moves to the previous row). No write.
- 0x0C FF: enter CLEAR.
- Any other control byte (including 0x7F and 0x80-0xFF): accepted and ignored.
- CLEAR state:
  - char_ready=0.
  - Clear counter runs 0..ROWS*COLS-1, one write per cycle: text_en=1, waddr=counter, new_char=CLEAR_GLYPH.
  - First clear write occurs the cycle after the FF is accepted.
  - After the write at ROWS*COLS-1: state=IDLE, cursor=(0,0), address=0, char_ready=1 on the next cycle.
  - Total: ROWS*COLS consecutive writes.
- Byte held on char_valid during CLEAR: not accepted. It is accepted on the first cycle char_ready returns to 1.
- Reset mid-CLEAR: abort immediately, no further writes, all outputs return to reset values. Cells already written are not restored.
- Back-to-back accepts: allowed every cycle in IDLE, giving one write per cycle.

Decomposition:
- Package text_console_pkg holds:
  - state enum {IDLE, CLEAR};
  - ASCII constants LF=8'h0A, CR=8'h0D, BS=8'h08, FF=8'h0C;
  - function ascii_to_glyph returning {hit, glyph[3:0]}.
- Sub-module text_cursor holds row/col/linear-address registers and computes advance/LF/CR/BS updates.
- text_console holds the FSM, clear counter, glyph decode and output registers.

Test Plan:
- Just after reset, present 'A' (0x41) with valid=1 -> accepted in cycle 0; cycle 1 text_en=1, waddr=0, new_char=0xA; cursor=(0,1).
- 81 consecutive '7' bytes -> writes at waddr 0..80, each new_char=7. The 81st goes to waddr 80; final cursor=(1,1).
- At cursor (0,5): LF, CR, then '3' -> no write for LF/CR; '3' writes waddr 80. At col 0, BS leaves the cursor and address unchanged.
- Cursor at (29,79), send 'f' -> write waddr 2399, new_char=15; cursor=(0,0). Next '1' writes waddr 0.
- FF with '2' held valid behind it:
  - 2400 writes, waddr 0..2399, new_char=CLEAR_GLYPH, char_ready=0 throughout.
  - '2' is accepted the cycle after the last clear write and writes waddr 0.
- rst_n low on clear write 1000 -> next cycle text_en=0, waddr=0, cursor=(0,0). char_ready=1 the first cycle after rst_n rises.
